posit_mul_stream: RTL and testbench

Streaming handshake and sign-handling shell around the LUT-based posit magnitude multiplier. Accepts operand pairs on a valid/ready port, converts them to sign plus magnitude, and drives the multiplier's address inputs. Tracks the multiplier's fixed pipeline latency with a sidecar shift register, then reapplies sign and zero/NaR overrides to the multiplier's result. Buffers results in a credit-guarded FIFO so downstream backpressure never drops a product.

---
 rtl/posit_mul_stream_if.sv | 29 ++
 rtl/posit_mul_stream.sv | 130 +++++++++++++
 tb/tb_posit_mul_stream.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_mul_stream_if.sv
// Stream-side signal bundle for posit_mul_stream: operand port, multiplier
// address/data port and result port.
interface posit_mul_stream_if #(
  parameter int POSIT_SIZE = 4
);
  // Both stream ports use plain valid/ready: a transfer happens on a rising
  // edge where VALID and READY are both high. The producer holds VALID and its
  // data until that edge; READY never depends on VALID in the same cycle.
  logic                  IN_VALID;
  logic                  IN_READY;
  logic [POSIT_SIZE-1:0] IN_A1;
  logic [POSIT_SIZE-1:0] IN_A2;
  logic [POSIT_SIZE-1:0] MUL_A1;
  logic [POSIT_SIZE-1:0] MUL_A2;
  logic [POSIT_SIZE-1:0] MUL_DATA;
  logic                  OUT_VALID;
  logic                  OUT_READY;
  logic [POSIT_SIZE-1:0] OUT_DATA;

  modport slave (
    input  IN_VALID, IN_A1, IN_A2, MUL_DATA, OUT_READY,
    output IN_READY, MUL_A1, MUL_A2, OUT_VALID, OUT_DATA
  );

  modport master (
    output IN_VALID, IN_A1, IN_A2, MUL_DATA, OUT_READY,
    input  IN_READY, MUL_A1, MUL_A2, OUT_VALID, OUT_DATA
  );
endinterface

// File: rtl/posit_mul_stream.sv
// Sign/special-case shell around a fixed-latency posit magnitude multiplier,
// with a sidecar pipe tracking in-flight pairs and a credit-guarded result FIFO.
module posit_mul_stream #(
  parameter int POSIT_SIZE = 4,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic               CLK,
  input logic               RST_N,
  posit_mul_stream_if.slave bus
);
  localparam int N  = POSIT_SIZE;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 1);
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  logic          accept;
  logic          push;
  logic          pop;
  logic          nar_c;
  logic          zero_c;
  logic          sign_c;
  logic [N-1:0]  mag_a1;
  logic [N-1:0]  mag_a2;
  logic [N-1:0]  mul_m;
  logic [N-1:0]  res_c;
  logic [IW-1:0] inflight;
  logic [31:0]   used_c;

  logic                rdy_en_q;
  logic [LATENCY-1:0]  vld_q;
  logic [LATENCY-1:0]  sgn_q;
  logic [LATENCY-1:0]  zro_q;
  logic [LATENCY-1:0]  nar_q;
  logic [N-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, wr_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [CW-1:0]       count_q, count_d;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mag_a1 = bus.IN_A1[N-1] ? -bus.IN_A1 : bus.IN_A1;
    mag_a2 = bus.IN_A2[N-1] ? -bus.IN_A2 : bus.IN_A2;
    nar_c  = (bus.IN_A1 == NAR) || (bus.IN_A2 == NAR);
    zero_c = !nar_c && ((bus.IN_A1 == '0) || (bus.IN_A2 == '0));
    sign_c = bus.IN_A1[N-1] ^ bus.IN_A2[N-1];
  end

  // Multiplier addresses follow the operands every cycle, accepted or not.
  assign bus.MUL_A1 = {1'b0, mag_a1[N-2:0]};
  assign bus.MUL_A2 = {1'b0, mag_a2[N-2:0]};

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + IW'(vld_q[i]);
  end

  // Credits come from registered state only, so a same-cycle pop never
  // feeds back into IN_READY.
  assign used_c       = 32'(inflight) + 32'(count_q);
  assign bus.IN_READY = rdy_en_q && (used_c < 32'(FIFO_DEPTH));
  assign accept       = bus.IN_VALID && bus.IN_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_en_q <= 1'b0;
      vld_q    <= '0;
      sgn_q    <= '0;
      zro_q    <= '0;
      nar_q    <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      vld_q[0] <= accept;
      sgn_q[0] <= sign_c;
      zro_q[0] <= zero_c;
      nar_q[0] <= nar_c;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        sgn_q[i] <= sgn_q[i-1];
        zro_q[i] <= zro_q[i-1];
        nar_q[i] <= nar_q[i-1];
      end
    end
  end

  always_comb begin
    mul_m = {1'b0, bus.MUL_DATA[N-2:0]};
    if (nar_q[LATENCY-1])      res_c = NAR;
    else if (zro_q[LATENCY-1]) res_c = '0;
    else if (sgn_q[LATENCY-1]) res_c = -mul_m;
    else                       res_c = mul_m;
  end

  assign push = vld_q[LATENCY-1];
  assign pop  = (count_q != '0) && bus.OUT_READY;

  always_comb begin
    wr_d    = push ? ptr_inc(wr_q) : wr_q;
    rd_d    = pop  ? ptr_inc(rd_q) : rd_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= res_c;
  end

  assign bus.OUT_VALID = (count_q != '0);
  assign bus.OUT_DATA  = bus.OUT_VALID ? mem_q[rd_q] : '0;
endmodule

// File: tb/tb_posit_mul_stream.sv
// Bench for posit_mul_stream: models a 2-cycle posit<4,0> magnitude multiplier
// and scoreboards every result against a value-level reference.
module tb_posit_mul_stream;
  localparam int POSIT_SIZE = 4;
  localparam int LATENCY    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int W          = POSIT_SIZE;

  logic CLK = 1'b0;
  logic RST_N;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] exp_q[$];
  int           out_cyc_q[$];
  logic         hold_q = 1'b0;
  logic [W-1:0] hold_data = '0;
  logic [W-1:0] m1_q, m2_q;

  posit_mul_stream_if #(.POSIT_SIZE(POSIT_SIZE)) bus ();

  posit_mul_stream #(
    .POSIT_SIZE(POSIT_SIZE),
    .LATENCY   (LATENCY),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- reference arithmetic ----------------
  function automatic real pval(input int k);
    case (k)
      1: return 0.25;
      2: return 0.5;
      3: return 0.75;
      4: return 1.0;
      5: return 1.5;
      6: return 2.0;
      7: return 4.0;
      default: return 0.0;
    endcase
  endfunction

  // Nearest posit<4,0> magnitude to the real product; zero magnitudes yield
  // an all-ones pattern so sign/zero overrides are genuinely exercised.
  function automatic logic [2:0] mag_tbl(input logic [2:0] x, input logic [2:0] y);
    real p, d, best_d;
    int  best;
    if (x == 3'd0 || y == 3'd0) return 3'b111;
    p = pval(int'(x)) * pval(int'(y));
    best = 1;
    best_d = 1.0e9;
    for (int k = 1; k < 8; k++) begin
      d = p - pval(k);
      if (d < 0.0) d = -d;
      if (d < best_d) begin
        best_d = d;
        best = k;
      end
    end
    return 3'(best);
  endfunction

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, ma, mb, m;
    if (a == 4'b1000 || b == 4'b1000) return 4'b1000;
    if (a == 4'b0000 || b == 4'b0000) return 4'b0000;
    sa = (int'(a) >= 8) ? int'(a) - 16 : int'(a);
    sb = (int'(b) >= 8) ? int'(b) - 16 : int'(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    m  = int'(mag_tbl(3'(ma), 3'(mb)));
    if ((sa < 0) != (sb < 0)) m = 16 - m;
    return 4'(m);
  endfunction

  // Multiplier model: two register stages, MSB of the result is junk.
  always @(posedge CLK) begin
    m1_q <= {1'($urandom_range(0, 1)), mag_tbl(bus.MUL_A1[2:0], bus.MUL_A2[2:0])};
    m2_q <= m1_q;
  end
  assign bus.MUL_DATA = m2_q;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    #2;
    if (RST_N) begin
      if (dut.push) check("push_not_full", 32'(dut.count_q == FIFO_DEPTH), 32'd0);
      if (hold_q && bus.OUT_VALID) check("out_data_stable", 32'(bus.OUT_DATA), 32'(hold_data));
      if (bus.OUT_VALID && bus.OUT_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %b expected no output (cycle %0d)", bus.OUT_DATA, cyc);
        end else begin
          check("out_data", 32'(bus.OUT_DATA), 32'(exp_q.pop_front()));
        end
        out_cyc_q.push_back(cyc);
      end
      hold_q    = bus.OUT_VALID && !bus.OUT_READY;
      hold_data = bus.OUT_DATA;
    end else begin
      hold_q = 1'b0;
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic drive_cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic ordy, output logic acc);
    bus.IN_VALID  = v;
    bus.IN_A1     = a;
    bus.IN_A2     = b;
    bus.OUT_READY = ordy;
    #1;
    acc = v && bus.IN_READY;
    if (acc) exp_q.push_back(ref_mul(a, b));
    @(negedge CLK);
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ema1, input logic [W-1:0] ema2,
                          input logic [W-1:0] eout);
    int lat;
    bus.IN_VALID  = 1'b1;
    bus.IN_A1     = a;
    bus.IN_A2     = b;
    bus.OUT_READY = 1'b1;
    #1;
    check("dir_in_ready", 32'(bus.IN_READY), 32'd1);
    check("dir_mul_a1", 32'(bus.MUL_A1), 32'(ema1));
    check("dir_mul_a2", 32'(bus.MUL_A2), 32'(ema2));
    if (bus.IN_READY) exp_q.push_back(ref_mul(a, b));
    @(negedge CLK);
    bus.IN_VALID = 1'b0;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      if (bus.OUT_VALID) begin
        lat = k;
        break;
      end
      @(negedge CLK);
    end
    check("dir_latency", 32'(lat), 32'd3);
    check("dir_out_data", 32'(bus.OUT_DATA), 32'(eout));
    @(negedge CLK);
  endtask

  task automatic drain(input int bound);
    logic acc;
    for (int i = 0; i < bound && exp_q.size() != 0; i++) drive_cycle(1'b0, '0, '0, 1'b1, acc);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    int   n, oc0;
    RST_N         = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.IN_A1     = '0;
    bus.IN_A2     = '0;
    bus.OUT_READY = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_in_ready", 32'(bus.IN_READY), 32'd0);
    check("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    check("rst_out_data", 32'(bus.OUT_DATA), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    #1;
    check("post_rst_in_ready", 32'(bus.IN_READY), 32'd1);
    @(negedge CLK);

    // directed products and special cases
    directed(4'b0110, 4'b0010, 4'b0110, 4'b0010, 4'b0100);
    directed(4'b1100, 4'b0110, 4'b0100, 4'b0110, 4'b1010);
    directed(4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    directed(4'b0000, 4'b0111, 4'b0000, 4'b0111, 4'b0000);
    drain(10);

    // backpressure: credits must stop at FIFO_DEPTH accepts
    n = 0;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 4'(i + 1), 4'($urandom_range(1, 7)), 1'b0, acc);
      n += int'(acc);
    end
    check("bp_accepts", 32'(n), 32'(FIFO_DEPTH));
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    oc0 = out_cyc_q.size();
    #1;
    check("bp_ready_same_cycle", 32'(bus.IN_READY), 32'd0);
    @(negedge CLK);
    #1;
    check("bp_ready_next_cycle", 32'(bus.IN_READY), 32'd1);
    repeat (3) @(negedge CLK);
    #3;
    check("bp_drain_count", 32'(out_cyc_q.size() - oc0), 32'(FIFO_DEPTH));
    if (out_cyc_q.size() - oc0 == FIFO_DEPTH)
      check("bp_drain_back_to_back", 32'(out_cyc_q[oc0 + FIFO_DEPTH - 1] - out_cyc_q[oc0]),
            32'(FIFO_DEPTH - 1));
    @(negedge CLK);
    drain(10);

    // sustained streaming
    oc0 = out_cyc_q.size();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 4'($urandom), 4'($urandom), 1'b1, acc);
      check("stream_accept", 32'(acc), 32'd1);
    end
    repeat (5) drive_cycle(1'b0, '0, '0, 1'b1, acc);
    check("stream_out_count", 32'(out_cyc_q.size() - oc0), 32'd10);
    if (out_cyc_q.size() - oc0 == 10)
      check("stream_consecutive", 32'(out_cyc_q[oc0 + 9] - out_cyc_q[oc0]), 32'd9);
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // random traffic with random backpressure
    for (int i = 0; i < 120; i++)
      drive_cycle(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                  1'($urandom_range(0, 3) != 0), acc);
    drain(30);

    // reset with two pairs in flight and one buffered
    n = 0;
    drive_cycle(1'b1, 4'b0101, 4'b0011, 1'b0, acc); n += int'(acc);
    drive_cycle(1'b0, '0, '0, 1'b0, acc);
    drive_cycle(1'b1, 4'b1101, 4'b0110, 1'b0, acc); n += int'(acc);
    drive_cycle(1'b1, 4'b0111, 4'b1110, 1'b0, acc); n += int'(acc);
    check("rst_mid_accepts", 32'(n), 32'd3);
    #1;
    check("rst_mid_buffered", 32'(bus.OUT_VALID), 32'd1);
    RST_N = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(bus.OUT_VALID), 32'd0);
    check("rst_mid_in_ready", 32'(bus.IN_READY), 32'd0);
    exp_q.delete();
    bus.IN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (8) drive_cycle(1'b0, '0, '0, 1'b1, acc);
    directed(4'b0110, 4'b0010, 4'b0110, 4'b0010, 4'b0100);
    drain(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
